// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the floating-point compare/min/max pipeline.
// Op codes, canonical NaNs, SP->DP exponent offset and operand class bits.
package fp_cmp_pkg;

  localparam logic [2:0] OP_FEQ  = 3'b000;
  localparam logic [2:0] OP_FLT  = 3'b001;
  localparam logic [2:0] OP_FLE  = 3'b010;
  localparam logic [2:0] OP_FMIN = 3'b011;
  localparam logic [2:0] OP_FMAX = 3'b100;

  localparam logic [63:0] CANON_NAN_DP = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] CANON_NAN_SP = 64'hFFFF_FFFF_7FC0_0000;

  // Exponent offset between SP (bias 127) and DP (bias 1023).
  localparam logic [10:0] SP_DP_BIAS = 11'd896;

  typedef struct packed {
    logic zero;
    logic inf;
    logic snan;
    logic qnan;
    logic sign;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Widens an SP operand to DP (NaN-box aware) and derives its class bits.
// Combinational, no state; backpressure not applicable.
module fp_classify
  import fp_cmp_pkg::*;
(
  input  logic [63:0] num,
  input  logic        fmt,
  output logic [63:0] wide,
  output fp_class_t   cls
);

  logic [10:0] sp_exp_dp;
  logic        exp_max;
  logic        man_nz;

  // Zero/subnormal and Inf/NaN exponents keep their special encodings.
  always_comb begin
    sp_exp_dp = 11'd0;
    case (num[30:23])
      8'h00:   sp_exp_dp = 11'd0;
      8'hFF:   sp_exp_dp = 11'h7FF;
      default: sp_exp_dp = {3'b000, num[30:23]} + SP_DP_BIAS;
    endcase
  end

  always_comb begin
    wide = num;
    if (!fmt) begin
      if (num[63:32] != 32'hFFFF_FFFF) begin
        wide = CANON_NAN_DP;
      end else begin
        wide = {num[31], sp_exp_dp, num[22:0], 29'd0};
      end
    end
  end

  assign exp_max  = &wide[62:52];
  assign man_nz   = |wide[51:0];
  assign cls.zero = (wide[62:0] == 63'd0);
  assign cls.inf  = exp_max & !man_nz;
  assign cls.snan = exp_max & man_nz & !wide[51];
  assign cls.qnan = exp_max & man_nz & wide[51];
  assign cls.sign = wide[63];

endmodule

// File: rtl/fp_cmp_pipe.sv
// FEQ/FLT/FLE/FMIN/FMAX on SP or DP operands with a sideband tag, 2 register stages.
// Latency 2 cycles; valid/ready, S1 holds and S2 holds stable while downstream stalls.
module fp_cmp_pipe
  import fp_cmp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  input  logic [2:0]            in_op,
  input  logic                  in_fmt,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_flag_NV
);

  logic [DATA_WIDTH-1:0] wide_a, wide_b;
  fp_class_t             cls_a, cls_b;

  fp_classify u_cls_a (.num(in_numA), .fmt(in_fmt), .wide(wide_a), .cls(cls_a));
  fp_classify u_cls_b (.num(in_numB), .fmt(in_fmt), .wide(wide_b), .cls(cls_b));

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_a, s1_b, s1_wa, s1_wb;
  fp_class_t             s1_ca, s1_cb;
  logic [2:0]            s1_op;
  logic                  s1_fmt;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s2_vld;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [TAG_WIDTH-1:0]  s2_tag;
  logic                  s2_nv;

  logic advance;

  assign advance   = !s2_vld | in_ready;
  assign out_ready = !s1_vld | advance;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_wa  <= '0;
      s1_wb  <= '0;
      s1_ca  <= '0;
      s1_cb  <= '0;
      s1_op  <= '0;
      s1_fmt <= 1'b0;
      s1_tag <= '0;
    end else if (out_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_a   <= in_numA;
        s1_b   <= in_numB;
        s1_wa  <= wide_a;
        s1_wb  <= wide_b;
        s1_ca  <= cls_a;
        s1_cb  <= cls_b;
        s1_op  <= in_op;
        s1_fmt <= in_fmt;
        s1_tag <= in_tag;
      end
    end
  end

  logic a_nan, b_nan, any_nan, any_snan, both_zero;
  logic mag_lt, mag_gt, total_lt, same_bits, is_eq, is_lt;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_nv;

  assign a_nan     = s1_ca.snan | s1_ca.qnan;
  assign b_nan     = s1_cb.snan | s1_cb.qnan;
  assign any_nan   = a_nan | b_nan;
  assign any_snan  = s1_ca.snan | s1_cb.snan;
  assign both_zero = s1_ca.zero & s1_cb.zero;
  assign same_bits = (s1_wa == s1_wb);

  // Magnitude order on the widened encoding; Inf beats every finite value.
  assign mag_lt = (s1_cb.inf & !s1_ca.inf) |
                  (!s1_ca.inf & !s1_cb.inf & (s1_wa[62:0] < s1_wb[62:0]));
  assign mag_gt = (s1_ca.inf & !s1_cb.inf) |
                  (!s1_ca.inf & !s1_cb.inf & (s1_wa[62:0] > s1_wb[62:0]));

  // Total order with -0 < +0; the numeric compares mask the zero pair out.
  assign total_lt = (s1_ca.sign != s1_cb.sign) ? s1_ca.sign :
                    (s1_ca.sign ? mag_gt : mag_lt);
  assign is_eq    = both_zero | same_bits;
  assign is_lt    = !both_zero & total_lt;

  always_comb begin
    res_data = '0;
    res_nv   = 1'b0;
    case (s1_op)
      OP_FEQ: begin
        res_data = {{(DATA_WIDTH-1){1'b0}}, !any_nan & is_eq};
        res_nv   = any_snan;
      end
      OP_FLT: begin
        res_data = {{(DATA_WIDTH-1){1'b0}}, !any_nan & is_lt};
        res_nv   = any_nan;
      end
      OP_FLE: begin
        res_data = {{(DATA_WIDTH-1){1'b0}}, !any_nan & (is_lt | is_eq)};
        res_nv   = any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        res_nv = any_snan;
        if (a_nan & b_nan) begin
          res_data = s1_fmt ? CANON_NAN_DP : CANON_NAN_SP;
        end else if (a_nan) begin
          res_data = s1_b;
        end else if (b_nan) begin
          res_data = s1_a;
        end else if ((s1_op == OP_FMIN) == (total_lt | same_bits)) begin
          res_data = s1_a;
        end else begin
          res_data = s1_b;
        end
      end
      default: begin
        res_data = '0;
        res_nv   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s2_vld  <= 1'b0;
      s2_data <= '0;
      s2_tag  <= '0;
      s2_nv   <= 1'b0;
    end else if (advance) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_data <= res_data;
        s2_tag  <= s1_tag;
        s2_nv   <= res_nv;
      end
    end
  end

  assign out_valid   = s2_vld;
  assign out_data    = s2_data;
  assign out_tag     = s2_tag;
  assign out_flag_NV = s2_nv;

endmodule

// File: doc/fp_cmp_pipe.md
FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand/result width; only 64 is supported.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, width of the sideband tag carried with each operation.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 in_clk  input  1  clock; all state updates on rising edge.
REQ-005 in_rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  request valid.
REQ-007 out_ready  output  1  module accepts a request this cycle.
REQ-008 in_numA, in_numB  input  DATA_WIDTH  operands.
REQ-009 in_op  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, 101-111 reserved.
REQ-010 in_fmt  input  1  1 = double precision, 0 = single precision (bits [31:0]).
REQ-011 in_tag  input  TAG_WIDTH  sideband tag returned unchanged with the result.
REQ-012 out_valid  output  1  result valid.
REQ-013 in_ready  input  1  downstream accepts the result this cycle.
REQ-014 out_data  output  DATA_WIDTH  result.
REQ-015 out_tag  output  TAG_WIDTH  tag of the result.
REQ-016 out_flag_NV  output  1  invalid-operation flag, qualified by out_valid.

Function
REQ-017 A transfer in SHALL occur when in_valid & out_ready; a transfer out SHALL occur when out_valid & in_ready.
REQ-018 The pipeline SHALL have 2 register stages: S1 latches the classified operands, op, fmt and tag; S2 latches the result, flag and tag.
REQ-019 Latency SHALL be 2 cycles from accept to out_valid when the pipeline is not stalled.
REQ-020 Throughput SHALL be 1 operation per cycle while in_ready=1.
REQ-021 Stage advance condition advance = !S2_valid | in_ready; out_ready SHALL equal !S1_valid | advance.
REQ-022 S1 SHALL hold its contents while !advance.
REQ-023 out_data, out_tag and out_flag_NV SHALL remain stable while out_valid & !in_ready.
REQ-024 No request SHALL be dropped or duplicated under any in_valid/in_ready pattern.
REQ-025 Single-precision operands SHALL be widened exactly to double: exponent + 896, mantissa << 29, with zero, subnormal, Inf and NaN handled correctly, i.e. not rebiased.
REQ-026 A single-precision operand whose bits [63:32] are not all ones SHALL be treated as canonical qNaN (NaN-boxing).
REQ-027 FEQ, FLT and FLE SHALL return 64'd1 when true and 64'd0 otherwise.
REQ-028 For FEQ, FLT and FLE, -0 SHALL equal +0.
REQ-029 Ordering SHALL be numeric and sign-magnitude correct, including both operands negative.
REQ-030 FEQ SHALL raise NV only on a signalling NaN; FLT and FLE SHALL raise NV on any NaN; any NaN SHALL give result 0.
REQ-031 FMIN and FMAX SHALL order -0 < +0.
REQ-032 FMIN and FMAX with exactly one NaN operand SHALL return the other operand.
REQ-033 FMIN and FMAX with both operands NaN SHALL return canonical NaN: DP 64'h7FF8_0000_0000_0000, SP 64'hFFFF_FFFF_7FC0_0000.
REQ-034 FMIN and FMAX SHALL raise NV only on a signalling NaN.
REQ-035 FMIN and FMAX SP results SHALL be NaN-boxed (upper 32 bits all ones).
REQ-036 Reserved ops SHALL return 64'd0 with NV=0.

Reset
REQ-037 On in_rst_n low, S1_valid, S2_valid, out_valid, out_data, out_tag and out_flag_NV SHALL be 0 immediately, without waiting for a clock edge.
REQ-038 Operations in flight when reset asserts SHALL be discarded.
REQ-039 out_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-040 Package fp_cmp_pkg SHALL hold the op-code constants, canonical NaN constants, SP-to-DP exponent bias offset (896) and the operand class struct (zero, inf, snan, qnan, sign).
REQ-041 Sub-module fp_classify SHALL be instantiated once per operand: widen, NaN-box check, class bits; combinational, placed before S1.

Verification
REQ-042 DP FLT with A=-2.0 (C000_0000_0000_0000) and B=-1.0 (BFF0_0000_0000_0000) SHALL give out_data=1, NV=0, 2 cycles after accept.
REQ-043 SP FEQ with A=FFFF_FFFF_8000_0000 and B=FFFF_FFFF_0000_0000 SHALL give out_data=1; the same with FMIN SHALL give FFFF_FFFF_8000_0000.
REQ-044 DP FLE with A=7FF4_0000_0000_0000 (sNaN) and B=1.0 SHALL give out_data=0, NV=1; FEQ with A=7FF8_0000_0000_0000 (qNaN) SHALL give out_data=0, NV=0.
REQ-045 FMAX, SP, A=0000_0000_3F80_0000 (not NaN-boxed) and B=FFFF_FFFF_4000_0000 SHALL give FFFF_FFFF_4000_0000, NV=0.
REQ-046 Stream 8 tagged requests with in_ready toggling 1,0,0,1,... SHALL return all 8 results in order with matching tags and outputs held stable during stalls.
REQ-047 Asserting in_rst_n low with 2 operations in flight SHALL drive out_valid=0 immediately, produce no results from those operations after release, and give out_ready=1.
